sum_arbiter: RTL

Shared-accumulator controller. Arbitrates up to N_REQ requesters for one saturating unsigned accumulator. A granted requester streams a burst of `len` samples, and the block returns the burst total with the requester ID and an overflow flag over a valid/ready result handshake. It sits between the sample producers and the result consumer and owns both the accumulator datapath and the round-robin schedule.

---
 rtl/sum_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sum_arbiter.sv
// Round-robin arbiter in front of one saturating accumulator.
// A granted requester streams a burst; the total is returned over valid/ready.
module sum_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*LEN_W-1:0]  len,
    input  logic [N_REQ*DATA_W-1:0] data,
    input  logic [N_REQ-1:0]        data_valid,
    output logic [N_REQ-1:0]        data_ready,
    output logic [N_REQ-1:0]        gnt,
    output logic                    busy,
    output logic [SUM_W-1:0]        result,
    output logic [ID_W-1:0]         result_id,
    output logic                    result_overflow,
    output logic                    result_valid,
    input  logic                    result_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [LEN_W-1:0]  win_len;
    logic [DATA_W-1:0] cur_data;
    logic              cur_valid;
    logic [SUM_W:0]    sum;

    // Scan from the far end so the entry closest to ptr is written last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int p;
            p = int'(ptr_q) + k;
            if (p >= N_REQ) p = p - N_REQ;
            if (req[p]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(p);
            end
        end
    end

    assign win_len   = len[int'(win_idx)*LEN_W +: LEN_W];
    assign cur_data  = data[int'(id_q)*DATA_W +: DATA_W];
    assign cur_valid = data_valid[id_q];
    assign sum       = {1'b0, acc_q} + (SUM_W+1)'(cur_data);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    id_d  = win_idx;
                    cnt_d = win_len;
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (win_len == '0) begin
                        state_d = S_DONE;
                        gnt_d   = '0;
                    end else begin
                        state_d = S_ACCUM;
                        gnt_d   = N_REQ'(1) << win_idx;
                    end
                end
            end
            S_ACCUM: begin
                if (cur_valid) begin
                    cnt_d = cnt_q - 1'b1;
                    // Once saturated, stay pinned at all-ones.
                    if (sum[SUM_W] || ovf_q) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[SUM_W-1:0];
                    end
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                        gnt_d   = '0;
                    end
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                    if (id_q == ID_W'(N_REQ - 1)) ptr_d = '0;
                    else ptr_d = id_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign gnt             = gnt_q;
    assign data_ready      = gnt_q;
    assign busy            = (state_q != S_IDLE);
    assign result          = acc_q;
    assign result_id       = id_q;
    assign result_overflow = ovf_q;
    assign result_valid    = (state_q == S_DONE);

endmodule
